// File: rtl/csa_256_arb.sv
// Round-robin arbiter that shares one csa_256 adder among three requesters.
// Each transaction walks IDLE -> ISSUE -> WAIT -> RESP, with an abort on timeout.
module csa_256_arb #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2:0]     req,
  input  logic [767:0]   op_a,
  input  logic [767:0]   op_b,
  input  logic [767:0]   op_c,
  output logic [2:0]     gnt,
  output logic [2:0]     rsp_done,
  output logic [256:0]   rsp_s,
  output logic           rsp_cout,
  output logic           rsp_err,
  output logic           busy,
  output logic [255:0]   csa_a,
  output logic [255:0]   csa_b,
  output logic [255:0]   csa_c,
  output logic           csa_start,
  input  logic [256:0]   csa_s,
  input  logic           csa_cout,
  input  logic           csa_done
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [1:0]      ptr;
  logic [1:0]      g_idx;
  logic [CW-1:0]   wait_cnt;
  logic            done_q;
  logic            pick_vld;
  logic [1:0]      pick_idx;
  logic [1:0]      cand;
  logic            done_edge;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // First requesting index found searching ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = wrap3({1'b0, ptr} + 3'(k));
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // done_q tracks csa_done every cycle so a level left over from an earlier
  // operation never looks like a fresh completion.
  assign done_edge = csa_done && !done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      g_idx     <= '0;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      gnt       <= '0;
      rsp_done  <= '0;
      rsp_s     <= '0;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      csa_a     <= '0;
      csa_b     <= '0;
      csa_c     <= '0;
      csa_start <= 1'b0;
    end else begin
      done_q <= csa_done;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt       <= 3'(3'b001 << pick_idx);
            g_idx     <= pick_idx;
            csa_a     <= op_a[256*int'(pick_idx) +: 256];
            csa_b     <= op_b[256*int'(pick_idx) +: 256];
            csa_c     <= op_c[256*int'(pick_idx) +: 256];
            csa_start <= 1'b1;
            busy      <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          csa_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (done_edge) begin
            rsp_s    <= csa_s;
            rsp_cout <= csa_cout;
            rsp_done <= gnt;
            state    <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_err  <= 1'b1;
            rsp_done <= gnt;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_done <= '0;
          gnt      <= '0;
          busy     <= 1'b0;
          ptr      <= wrap3({1'b0, g_idx} + 3'd1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/csa_256_arb.md
CSA_256_ARB -- requirements
Module: csa_256_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum cycles to wait for csa_done before aborting.
REQ-003 Ports SHALL be exactly (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  3  per-requester level request
- op_a, op_b, op_c  in  768 each  per-requester operands; requester i occupies bits [256*i+255:256*i]
- gnt  out  3  one-hot; current transaction owner
- rsp_done  out  3  one-hot, one-cycle completion pulse
- rsp_s  out  257  result sum
- rsp_cout  out  1  result carry-out
- rsp_err  out  1  timeout flag; qualified by rsp_done
- busy  out  1  high in any state other than IDLE
- csa_a, csa_b, csa_c  out  256 each  operands driven to the shared csa_256
- csa_start  out  1  one-cycle start pulse to csa_256
- csa_s  in  257  csa_256 sum
- csa_cout  in  1  csa_256 carry-out
- csa_done  in  1  csa_256 done (level or pulse)

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-005 IDLE: if any req bit is high, the block SHALL grant one requester by round-robin from pointer ptr (search order ptr, ptr+1, ptr+2, mod 3), set gnt, latch that requester's operands into csa_a/b/c, and enter ISSUE; otherwise it stays in IDLE.
REQ-006 ISSUE SHALL last exactly one cycle with csa_start=1, then the FSM SHALL go to WAIT.
REQ-007 WAIT SHALL detect completion only on a rising edge of csa_done, using a registered previous value of csa_done, so a stale high level left from the prior operation is ignored.
REQ-008 On the detected edge, the block SHALL capture csa_s and csa_cout into rsp_s and rsp_cout, and go to RESP.
REQ-009 A WAIT cycle counter SHALL start at 0 on WAIT entry; when it reaches TIMEOUT-1 without an edge, the block SHALL set rsp_err=1, leave rsp_s and rsp_cout unchanged, and go to RESP.
REQ-010 RESP SHALL last one cycle with rsp_done[g]=1 for granted index g, and SHALL set ptr=(g+1) mod 3.
REQ-011 At the end of RESP, gnt SHALL clear and the FSM SHALL return to IDLE.
REQ-012 rsp_s and rsp_cout SHALL hold their values until the next capture.
REQ-013 rsp_err SHALL clear on the next grant.
REQ-014 Latency SHALL be: req seen in IDLE at cycle 0; csa_start at cycle 1; rsp_done exactly one cycle after the csa_done edge.
REQ-015 The minimum turnaround between grants SHALL be 4 cycles (IDLE, ISSUE, WAIT, RESP).
REQ-016 Operands SHALL be latched at grant; op changes after grant SHALL have no effect.
REQ-017 If req[g] deasserts after grant, the transaction SHALL still complete and rsp_done[g] SHALL still pulse.
REQ-018 Requests arriving while busy SHALL wait; none SHALL be lost while held high.
REQ-019 csa_done edges outside WAIT SHALL be ignored.

Reset
REQ-020 On rst_n=0, asynchronously: state=IDLE, ptr=0, and every output (gnt, rsp_done, rsp_s, rsp_cout, rsp_err, busy, csa_a/b/c, csa_start) SHALL be 0.
REQ-021 Reset during ISSUE, WAIT or RESP SHALL abort the transaction with no rsp_done.
REQ-022 After rst_n rises, the first grant SHALL follow REQ-005 with ptr=0.

Verification
REQ-023 Single request: req=001, op0 = 125, 421, 15; stub csa returns 561, cout 0 after 3 cycles -> csa_start at cycle 1; rsp_done=001, rsp_s=561, rsp_cout=0, rsp_err=0.
REQ-024 Contention: req=111 held high from reset -> grant order 0,1,2,0; each rsp_done matches its own operands (3125+1421+155=4701 on requester 1).
REQ-025 Fairness: req=101 continuous after requester 0 served -> next grant is 2, then 0.
REQ-026 Stale done: stub holds csa_done high until the next start -> no premature completion; response comes on the new rising edge only.
REQ-027 Timeout: stub never asserts csa_done, TIMEOUT=64 -> rsp_done pulses 65 cycles after csa_start with rsp_err=1; next grant clears rsp_err.
REQ-028 Reset in WAIT: rst_n=0 for 2 cycles mid-WAIT -> all outputs 0, no rsp_done; a new req=010 is then served normally.
